key_sequencer: RTL and testbench

// Transmit end of the digitalLock key interface: plays a stored N-digit code onto a 4-bit key bus.

---
 rtl/key_sequencer.sv | 168 ++++++++++++++++
 tb/tb_key_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/key_sequencer.sv
// key_sequencer: plays a stored multi-digit code onto a 4-bit key bus as
// timed press/release pairs, with start/busy/done handshake and abort.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; rejects codes containing a zero nibble
// PRESS   | current nibble driven on key for PRESS_CYCLES cycles
// RELEASE | key = 0 for RELEASE_CYCLES cycles between digits
// DONE    | one-cycle done pulse, then back to IDLE
module key_sequencer #(
  parameter int CLOCK_FREQ      = 50000000,
  parameter int PRESS_CYCLES    = CLOCK_FREQ / 100,
  parameter int RELEASE_CYCLES  = CLOCK_FREQ / 100,
  parameter int PASSCODE_LENGTH = 4,
  parameter int PASSCODE_WIDTH  = 4 * PASSCODE_LENGTH,
  parameter int HOLD_WIDTH      = $clog2(((PRESS_CYCLES > RELEASE_CYCLES) ?
                                          PRESS_CYCLES : RELEASE_CYCLES) + 1),
  parameter int INDEX_WIDTH     = $clog2(PASSCODE_LENGTH + 1)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic [PASSCODE_WIDTH-1:0] code,
  input  logic                      abort,
  output logic [3:0]                key,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  output logic [INDEX_WIDTH-1:0]    digit_index
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESS   = 2'd1,
    RELEASE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [HOLD_WIDTH-1:0]  PRESS_LAST   = HOLD_WIDTH'(PRESS_CYCLES - 1);
  localparam logic [HOLD_WIDTH-1:0]  RELEASE_LAST = HOLD_WIDTH'(RELEASE_CYCLES - 1);
  localparam logic [INDEX_WIDTH-1:0] LAST_DIGIT   = INDEX_WIDTH'(PASSCODE_LENGTH - 1);

  state_t                    state, state_n;
  logic [HOLD_WIDTH-1:0]     hold_cnt, hold_cnt_n;
  logic [PASSCODE_WIDTH-1:0] code_reg, code_reg_n;
  logic [3:0]                key_n;
  logic                      busy_n, done_n, error_n;
  logic [INDEX_WIDTH-1:0]    digit_index_n;
  logic                      has_zero;
  logic [PASSCODE_WIDTH-1:0] code_shifted;

  // Detect any all-zero nibble in the requested code; such a code cannot be keyed.
  always_comb begin
    has_zero = 1'b0;
    for (int i = 0; i < PASSCODE_LENGTH; i++) begin
      if (code[4*i +: 4] == 4'd0) has_zero = 1'b1;
    end
  end

  assign code_shifted = code_reg << 4;

  // State and registered outputs; key drops to 0 asynchronously on reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      hold_cnt    <= '0;
      code_reg    <= '0;
      key         <= 4'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      digit_index <= '0;
    end else begin
      state       <= state_n;
      hold_cnt    <= hold_cnt_n;
      code_reg    <= code_reg_n;
      key         <= key_n;
      busy        <= busy_n;
      done        <= done_n;
      error       <= error_n;
      digit_index <= digit_index_n;
    end
  end

  // Next-state and next-output decode; hold counter restarts on every state entry.
  always_comb begin
    state_n       = state;
    hold_cnt_n    = hold_cnt;
    code_reg_n    = code_reg;
    key_n         = key;
    busy_n        = busy;
    done_n        = 1'b0;
    error_n       = 1'b0;
    digit_index_n = digit_index;

    case (state)
      IDLE: begin
        key_n  = 4'd0;
        busy_n = 1'b0;
        if (start && !abort) begin
          if (has_zero) begin
            error_n = 1'b1;
          end else begin
            code_reg_n    = code;
            digit_index_n = '0;
            key_n         = code[PASSCODE_WIDTH-1 -: 4];
            busy_n        = 1'b1;
            hold_cnt_n    = '0;
            state_n       = PRESS;
          end
        end
      end

      PRESS: begin
        if (abort) begin
          key_n      = 4'd0;
          busy_n     = 1'b0;
          hold_cnt_n = '0;
          state_n    = IDLE;
        end else if (hold_cnt == PRESS_LAST) begin
          key_n      = 4'd0;
          hold_cnt_n = '0;
          state_n    = RELEASE;
        end else begin
          hold_cnt_n = hold_cnt + HOLD_WIDTH'(1);
        end
      end

      RELEASE: begin
        if (abort) begin
          key_n      = 4'd0;
          busy_n     = 1'b0;
          hold_cnt_n = '0;
          state_n    = IDLE;
        end else if (hold_cnt == RELEASE_LAST) begin
          hold_cnt_n    = '0;
          digit_index_n = digit_index + INDEX_WIDTH'(1);
          if (digit_index == LAST_DIGIT) begin
            busy_n  = 1'b0;
            done_n  = 1'b1;
            state_n = DONE;
          end else begin
            code_reg_n = code_shifted;
            key_n      = code_shifted[PASSCODE_WIDTH-1 -: 4];
            state_n    = PRESS;
          end
        end else begin
          hold_cnt_n = hold_cnt + HOLD_WIDTH'(1);
        end
      end

      DONE: begin
        key_n      = 4'd0;
        busy_n     = 1'b0;
        hold_cnt_n = '0;
        state_n    = IDLE;
      end

      default: begin
        key_n      = 4'd0;
        busy_n     = 1'b0;
        hold_cnt_n = '0;
        state_n    = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_key_sequencer.sv
// Bench for key_sequencer: directed and randomized code sequences checked
// against a waveform model derived from digit timing arithmetic.
module tb_key_sequencer;

  localparam int P   = 3;
  localparam int R   = 2;
  localparam int LEN = 4;
  localparam int W   = 4 * LEN;
  localparam int IW  = $clog2(LEN + 1);

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  code  = '0;
  logic          abort = 1'b0;
  logic [3:0]    key;
  logic          busy, done, error;
  logic [IW-1:0] digit_index;

  int vectors     = 0;
  int miscompares = 0;

  key_sequencer #(
    .CLOCK_FREQ(1000), .PRESS_CYCLES(P), .RELEASE_CYCLES(R), .PASSCODE_LENGTH(LEN)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .code(code), .abort(abort),
    .key(key), .busy(busy), .done(done), .error(error), .digit_index(digit_index)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [3:0] nibble(input logic [W-1:0] c, input int d);
    logic [W-1:0] s;
    s = c >> (4 * (LEN - 1 - d));
    return s[3:0];
  endfunction

  function automatic logic [W-1:0] rand_code();
    logic [W-1:0] c;
    c = '0;
    for (int i = 0; i < LEN; i++) c = (c << 4) | W'($urandom_range(1, 15));
    return c;
  endfunction

  task automatic check_idle(input string tag, input logic [IW-1:0] idx);
    check({tag, "_key"},  key, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_idx"},  digit_index, idx);
  endtask

  // Launch a sequence and check every cycle against the timing model.
  // abort_at/inject_at: cycle number (1-based) to abort or pulse a stray start; 0 = none.
  task automatic run_seq(input logic [W-1:0] c, input int abort_at, input int inject_at);
    int d, ph;
    logic [3:0] ek;
    start = 1'b1;
    code  = c;
    step();
    start = 1'b0;
    code  = W'($urandom);
    for (int cyc = 1; cyc <= LEN * (P + R); cyc++) begin
      d  = (cyc - 1) / (P + R);
      ph = (cyc - 1) % (P + R);
      ek = (ph < P) ? nibble(c, d) : 4'd0;
      check("seq_key",   key, ek);
      check("seq_busy",  busy, 1);
      check("seq_done",  done, 0);
      check("seq_error", error, 0);
      check("seq_idx",   digit_index, d);
      start = 1'b0;
      if (cyc == inject_at) begin
        start = 1'b1;
        code  = 16'h1111;
      end
      if (cyc == abort_at) begin
        abort = 1'b1;
        step();
        abort = 1'b0;
        for (int k = 0; k < 4; k++) begin
          check_idle("abort", IW'(d));
          step();
        end
        return;
      end
      step();
    end
    start = 1'b0;
    check("end_done",  done, 1);
    check("end_busy",  busy, 0);
    check("end_key",   key, 0);
    check("end_error", error, 0);
    check("end_idx",   digit_index, LEN);
    step();
    check("post_done", done, 0);
    check("post_busy", busy, 0);
    check("post_idx",  digit_index, LEN);
    step();
  endtask

  initial begin
    logic [W-1:0] zc;
    int z;

    #2;
    check("rst_key",   key, 0);
    check("rst_busy",  busy, 0);
    check("rst_done",  done, 0);
    check("rst_error", error, 0);
    check("rst_idx",   digit_index, 0);
    step();
    reset = 1'b1;
    step();

    // Nominal code
    run_seq(16'h8148, 0, 0);

    // Zero-digit reject, directed then random position
    for (int n = 0; n < 4; n++) begin
      zc = (n == 0) ? 16'h8108 : rand_code();
      z  = (n == 0) ? 2 : $urandom_range(0, LEN - 1);
      zc = zc & ~(W'(4'hF) << (4 * (LEN - 1 - z)));
      start = 1'b1;
      code  = zc;
      step();
      start = 1'b0;
      check("rej_error", error, 1);
      check_idle("rej1", LEN);
      step();
      check("rej_error2", error, 0);
      check_idle("rej2", LEN);
      step();
    end

    // start with abort together: abort wins, nothing happens
    start = 1'b1;
    abort = 1'b1;
    code  = 16'h2345;
    step();
    start = 1'b0;
    abort = 1'b0;
    check("sa_error", error, 0);
    check_idle("sa", LEN);
    step();
    check_idle("sa2", LEN);

    // Abort during second digit press
    run_seq(16'h8148, 6, 0);

    // Stray start while busy, then a real start of the injected code
    run_seq(16'h8148, 0, 10);
    run_seq(16'h1111, 0, 0);

    // Randomized codes, random abort/inject points
    for (int n = 0; n < 8; n++) begin
      run_seq(rand_code(), (n % 3 == 2) ? int'($urandom_range(1, LEN * (P + R))) : 0,
              (n % 2 == 1) ? int'($urandom_range(1, LEN * (P + R))) : 0);
    end

    // Reset asserted mid-sequence
    start = 1'b1;
    code  = 16'h8148;
    step();
    start = 1'b0;
    for (int cyc = 1; cyc < 12; cyc++) step();
    check("pre_rst_busy", busy, 1);
    reset = 1'b0;
    #1;
    check("mrst_key",  key, 0);
    check("mrst_busy", busy, 0);
    check("mrst_idx",  digit_index, 0);
    step();
    check_idle("mrst_hold", 0);
    reset = 1'b1;
    step();
    run_seq(16'h8148, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
